// File: rtl/axi_wr_slave.sv
// AXI write-channel slave that turns each accepted write burst into a
// sequence of single-cycle memory write strobes, then returns one response.
// FIXED, INCR and WRAP bursts are supported; malformed bursts are consumed
// and answered with SLVERR.
module axi_wr_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    // write address channel
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data channel
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response channel
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    // memory write port
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int MAX_SIZE = $clog2(STRB_W);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

    state_t state, state_nxt;

    // Burst context captured on the address handshake.
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        cnt_q;
    logic              err_q;      // sticky: any error seen in this burst
    logic              cfg_err_q;  // error known at AW time: writes suppressed

    logic              aw_hs;
    logic              w_hs;
    logic              last_beat;
    logic              cfg_bad;
    logic              wlast_bad;
    logic [ADDR_W-1:0] beat_bytes;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_nxt;

    // Handshake outputs are pure functions of the state; awready is also
    // held low while reset is asserted.
    assign awready = (state == IDLE) && !rst;
    assign wready  = (state == DATA);
    assign bvalid  = (state == RESP);
    assign bid     = bvalid ? id_q : '0;
    assign bresp   = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign last_beat = (cnt_q == len_q);
    assign wlast_bad = (wlast != last_beat);

    // Decode AW-time errors and the address of the next beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cfg_bad    = 1'b0;
        beat_bytes = ADDR_W'(1) << size_q;
        wrap_mask  = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        addr_nxt   = addr_q;

        if (awburst == 2'b11)
            cfg_bad = 1'b1;
        if (awburst == BURST_WRAP && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
            cfg_bad = 1'b1;
        if (awsize > 3'(MAX_SIZE))
            cfg_bad = 1'b1;

        case (burst_q)
            BURST_FIXED: addr_nxt = addr_q;
            BURST_INCR:  addr_nxt = addr_q + beat_bytes;
            BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
            default:     addr_nxt = addr_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: one burst at a time, IDLE -> DATA -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs)             state_nxt = DATA;
            DATA:    if (w_hs && last_beat) state_nxt = RESP;
            RESP:    if (bready)            state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Burst context, beat counting, error tracking and the memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            // NOTE: mem_we defaults low each cycle so it is a one-cycle pulse per accepted beat.
            mem_we <= 1'b0;

            if (aw_hs) begin
                id_q      <= awid;
                addr_q    <= awaddr;
                len_q     <= awlen;
                size_q    <= awsize;
                burst_q   <= awburst;
                cnt_q     <= '0;
                err_q     <= cfg_bad;
                cfg_err_q <= cfg_bad;
            end

            if (w_hs) begin
                if (!cfg_err_q) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= wdata;
                    mem_wstrb <= wstrb;
                end
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
                if (wlast_bad)
                    err_q <= 1'b1;
            end
        end
    end

endmodule
